// File: rtl/j_bcd_seq_adder.sv
// Sequential packed-BCD adder: one decimal digit per clock, least significant first.
// Operands are captured on start, digits ripple through a single BCD digit adder,
// and the result registers update once, when the FSM leaves RUN.
module j_bcd_seq_adder #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  input  logic                   cin,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;      // operands captured at acceptance
  logic [W-1:0]    acc;           // result digits built up during RUN
  logic            carry;         // decimal carry between digits
  logic            err_acc;       // any captured digit above 9 so far
  logic [IW-1:0]   idx;           // digit currently being added
  logic            last_q;        // all digits processed, publish next edge

  logic [3:0]      da, db, dig;
  logic [4:0]      s;
  logic            dc;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_q) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single BCD digit adder with decimal correction; valid for any 5-bit binary sum.
  always_comb begin
    da  = a_q[4*int'(idx) +: 4];
    db  = b_q[4*int'(idx) +: 4];
    s   = {1'b0, da} + {1'b0, db} + {4'b0000, carry};
    dig = s[3:0];
    dc  = 1'b0;
    if (s > 5'd9) begin
      dig = s[3:0] + 4'd6;  // (s + 6) mod 16, since 16 mod 16 is 0
      dc  = 1'b1;
    end
  end

  // Datapath: capture operands, step through digits, publish result on RUN->DONE.
  // NOTE: the datapath registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      err_acc <= 1'b0;
      idx     <= '0;
      last_q  <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_q     <= a;
        b_q     <= b;
        carry   <= cin;
        acc     <= '0;
        err_acc <= 1'b0;
        idx     <= '0;
        last_q  <= 1'b0;
      end else if (state == RUN && !last_q) begin
        acc[4*int'(idx) +: 4] <= dig;
        carry   <= dc;
        err_acc <= err_acc | (da > 4'd9) | (db > 4'd9);
        if (idx == LAST_IDX) last_q <= 1'b1;
        else                 idx    <= idx + IW'(1);
      end else if (state == RUN && last_q) begin
        sum  <= acc;
        cout <= carry;
        err  <= err_acc;
      end
    end
  end

endmodule

// File: tb/tb_j_bcd_seq_adder.sv
// Directed bench for j_bcd_seq_adder: a 4-digit instance for the main cases
// and a 1-digit instance for the degenerate width.
module tb_j_bcd_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cin;
  logic [15:0] a, b, sum;
  logic        ready, busy, done, cout, err;

  logic        start1, cin1;
  logic [3:0]  a1, b1, sum1;
  logic        ready1, busy1, done1, cout1, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  j_bcd_seq_adder #(.NDIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  j_bcd_seq_adder #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 4-digit instance. With disturb set, start is
  // re-pulsed with different operands while the first addition is running.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec,
                        input logic ee, input bit disturb);
    int cnt;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < 20) begin
      if (disturb && cnt == 1) begin
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
      end
      if (disturb && cnt == 3) start = 1'b0;
      tick;
      cnt++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(cnt), 32'd5);
    check({tag, ".sum"},  32'(sum),  32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".err"},  32'(err),  32'(ee));
    tick;
    check({tag, ".done_pulse"}, 32'(done),  32'd0);
    check({tag, ".ready"},      32'(ready), 32'd1);
  endtask

  initial begin
    int cnt;
    int ndone;
    rst_n = 1'b0; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;

    #12;
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.busy",  32'(busy),  32'd0);
    check("reset.done",  32'(done),  32'd0);
    check("reset.sum",   32'(sum),   32'd0);
    check("reset.cout",  32'(cout),  32'd0);
    check("reset.err",   32'(err),   32'd0);
    rst_n = 1'b1;
    tick;

    run_op("basic",  16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("max",    16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
    run_op("baddig", 16'h000F, 16'h0000, 1'b0, 16'h0015, 1'b0, 1'b1, 1'b0);
    run_op("ignore", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
    // Issued in the IDLE cycle right after the previous done.
    run_op("b2b",    16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0);

    // Abort while digit 2 is being processed.
    a = 16'h8888; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.busy",  32'(busy),  32'd0);
    check("abort.sum",   32'(sum),   32'd0);
    check("abort.cout",  32'(cout),  32'd0);
    check("abort.err",   32'(err),   32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick;
      if (done) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);

    // Single-digit instance.
    a1 = 4'h5; b1 = 4'h5; cin1 = 1'b0; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    cnt = 0;
    while (!done1 && cnt < 20) begin
      tick;
      cnt++;
    end
    check("n1.latency", 32'(cnt),   32'd2);
    check("n1.sum",     32'(sum1),  32'd0);
    check("n1.cout",    32'(cout1), 32'd1);
    check("n1.err",     32'(err1),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/j_bcd_seq_adder.md
J_BCD_SEQ_ADDER -- requirements
Module: j_bcd_seq_adder

Interface
REQ-001 The block SHALL have the parameter NDIGITS, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin an addition, sampled only while ready=1.
REQ-005 The block SHALL have the port a, input, 4*NDIGITS bits: operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 The block SHALL have the port b, input, 4*NDIGITS bits: operand B, same packing as a.
REQ-007 The block SHALL have the port cin, input, 1 bit: decimal carry into digit 0.
REQ-008 The block SHALL have the port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have the port busy, output, 1 bit: high only in RUN.
REQ-010 The block SHALL have the port done, output, 1 bit: single-cycle pulse, high only in DONE.
REQ-011 The block SHALL have the port sum, output, 4*NDIGITS bits: packed BCD result.
REQ-012 The block SHALL have the port cout, output, 1 bit: decimal carry out of the top digit.
REQ-013 The block SHALL have the port err, output, 1 bit: set if any operand digit exceeded 9.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start=1.
- RUN->RUN while the digit index is below NDIGITS-1.
- RUN->DONE after digit NDIGITS-1 is processed.
- DONE->IDLE unconditionally.
REQ-015 On accepting start, the block SHALL latch a, b and cin into internal registers; a, b and cin changes after acceptance SHALL have no effect on the result.
REQ-016 The block SHALL process exactly one digit per RUN cycle, least significant digit first, with the digit index counting 0..NDIGITS-1.
REQ-017 Per digit, the block SHALL form the 5-bit binary sum s = a_i + b_i + c, where c is cin for digit 0 and the previous digit's carry otherwise.
REQ-018 Correction: if s>9, the result digit SHALL be (s+6) mod 16 and the carry SHALL be 1; otherwise the digit SHALL be s and the carry 0. This rule applies to all s from 0 to 31.
REQ-019 The block SHALL set the internal err flag if any latched a_i or b_i is greater than 9; computation SHALL continue per REQ-018.
REQ-020 sum, cout and err SHALL update only on the RUN->DONE edge and SHALL hold until the next RUN->DONE edge.
REQ-021 Latency: with start accepted at edge T, done SHALL be high for the one cycle after edge T+NDIGITS+1 and low otherwise.
REQ-022 start SHALL be ignored in RUN and DONE, with no queuing.
REQ-023 Back-to-back operation: start may next be accepted in the IDLE cycle immediately after DONE.
REQ-024 NDIGITS=1 SHALL work with one RUN cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear these values regardless of clk: ready=1, busy=0, done=0, sum=0, cout=0, err=0, digit index 0 and internal carry 0.
REQ-026 A reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Verification (NDIGITS=4 unless stated; values hex-packed BCD)
REQ-027 a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0, done exactly 5 cycles after the accepting edge.
REQ-028 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1 (full carry ripple); a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-029 a=0x000F, b=0x0000, cin=0 -> err=1, sum=0x0015, cout=0; the next valid operation -> err=0.
REQ-030 start re-pulsed with new operands during RUN -> ignored, first result unchanged, exactly one done; start in the IDLE cycle after done -> accepted.
REQ-031 rst_n pulsed low during RUN digit 2 -> outputs zero, ready=1, no done; the following 0x0005+0x0005 -> sum=0x0010, cout=0.
REQ-032 NDIGITS=1: a=5, b=5, cin=0 -> sum=0, cout=1, done 2 cycles after acceptance.
